// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial, LSB-first WIDTH-bit unsigned adder. It is the inverse companion
// of the bit-serial subtractor: feeding it a difference plus the same
// subtrahend restores the original minuend.
//
// The datapath has four parts:
//    * an accumulator shift register. Sum bits enter at the MSB while operand
//      bits leave at the LSB.
//    * a cyclic addend register. It rotates right so that after WIDTH shifts
//      it holds its loaded value again.
//    * a carry flip-flop.
//    * a bit counter.
// A three-state FSM (IDLE / SHIFT / DONE) sequences the datapath with a
// four-phase start/done handshake.
//
// Ports:
//    CLK        clock; every state change happens on the rising edge
//    R          synchronous active-low reset; has priority over everything
//    St         start request (level); only looked at in IDLE and DONE
//    Acc_in     first operand, captured on the start edge
//    Addend_in  second operand, captured on the start edge
//    Sum        registered result (Acc_in + Addend_in) mod 2^WIDTH
//    Cout       registered carry out of the MSB
//    Sout       registered serial sum bit from the most recent shift
//    Busy       high while the FSM is in SHIFT
//    Done       high while the FSM is in DONE
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             St,
   input  logic [WIDTH-1:0] Acc_in,
   input  logic [WIDTH-1:0] Addend_in,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Sout,
   output logic             Busy,
   output logic             Done
);

   // WIDTH >= 2, so the counter is always at least one bit wide.
   localparam int CW = $clog2(WIDTH);

   // Counter value seen on the final shift edge.
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg,   acc_next;
   logic [WIDTH-1:0] add_reg,   add_next;
   logic             carry_reg, carry_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] sum_reg,   sum_next;
   logic             cout_reg,  cout_next;
   logic             sout_reg,  sout_next;
   logic             busy_reg,  busy_next;
   logic             done_reg,  done_next;

   // Full adder on the current LSBs.
   logic             s_bit;
   logic             c_bit;

   // Upper WIDTH-1 bits of each register moved down one position. The
   // accumulator takes the new sum bit on top. The addend takes its own LSB
   // on top, so it behaves as a rotate.
   logic [WIDTH-2:0] acc_shr;
   logic [WIDTH-2:0] add_shr;

   assign s_bit = acc_reg[0] ^ add_reg[0] ^ carry_reg;
   assign c_bit = (acc_reg[0] & add_reg[0]) |
                  (acc_reg[0] & carry_reg)  |
                  (add_reg[0] & carry_reg);

   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign acc_shr[gi] = acc_reg[gi + 1];
         assign add_shr[gi] = add_reg[gi + 1];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State register. Reset clears every flop, including Sum, so a reset in
   // the middle of an operation throws away the partial result.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!R) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         add_reg   <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         sout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         add_reg   <= add_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
         sout_reg  <= sout_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic. Every register holds unless the current
   // state says otherwise.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      add_next   = add_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      sout_next  = sout_reg;
      busy_next  = busy_reg;
      done_next  = done_reg;

      case (state_reg)
         IDLE: begin
            // Clear the carry on every load so that no carry leaks in from
            // the previous operation. Sum and Cout keep the last result.
            if (St) begin
               acc_next   = Acc_in;
               add_next   = Addend_in;
               carry_next = 1'b0;
               count_next = '0;
               busy_next  = 1'b1;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            // St and the operand inputs are deliberately ignored here. Once
            // an operation has started, it always runs exactly WIDTH shifts.
            acc_next   = {s_bit, acc_shr};
            add_next   = {add_reg[0], add_shr};
            carry_next = c_bit;
            sout_next  = s_bit;
            count_next = count_reg + CW'(1);

            // On the last shift, the accumulator's next value is already the
            // full result, so Sum and Cout are loaded from it directly.
            if (count_reg == LAST_COUNT) begin
               sum_next   = {s_bit, acc_shr};
               cout_next  = c_bit;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = DONE;
            end
         end

         DONE: begin
            // Four-phase handshake: St must be seen low before a new start
            // can be accepted in IDLE.
            if (!St) begin
               done_next  = 1'b0;
               state_next = IDLE;
            end
         end

         default: begin
            busy_next  = 1'b0;
            done_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign Sum  = sum_reg;
   assign Cout = cout_reg;
   assign Sout = sout_reg;
   assign Busy = busy_reg;
   assign Done = done_reg;

endmodule
